// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the decode-side pipeline control logic: hazard FSM
// state encoding, default register index width and the all-zero control word
// loaded into the ID/EX control buffer when a bubble is inserted.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned FLUSH_CNT_W    = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // Control fields carried in the ID/EX buffer.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use hazard compare between the ID source operands and
// the destination of a load currently in EX.
// Ports: ID operands/usage flags, EX buffered control and rd; loaduse_c out.
module hazard_loaduse_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  reg_memRead,
  input  logic                  reg_regWrite,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  loaduse_c
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_load;

  // x0 is hard-wired, so a load into it never creates a dependency.
  always_comb begin
    ex_load   = ex_valid & reg_memRead & reg_regWrite & (ex_rd != '0);
    rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
    loaduse_c = id_valid & ex_load & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: turns load-use hazards, EX redirects and data-memory
// busy into stall/flush/bubble controls for PC, IF/ID and the ID/EX buffer.
// Outputs are combinational from state and inputs (zero-cycle reaction).
// Ports: clock, reset (async active-low); ID operands, EX control, branch_taken,
//        mem_busy in; pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
//        stall_cycles, flush_cycles out.
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall/flush
//           performance counters; otherwise both count outputs are tied to 0.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CORE         = 0,
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  reg_memRead,
  input  logic                  reg_regWrite,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_hold,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  // Elaboration-time sanity on configuration.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 8 || CORE > 32'h0000_FFFF) begin : g_bad_cfg
    $error("pipeline_hazard_controller: illegal FLUSH_CYCLES or CORE");
  end

  hz_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   pending_redirect_q, pending_redirect_d;

  logic loaduse;
  logic redirect;
  logic do_run;
  logic take_redirect;

  hazard_loaduse_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_loaduse (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_valid     (ex_valid),
    .reg_memRead  (reg_memRead),
    .reg_regWrite (reg_regWrite),
    .ex_rd        (ex_rd),
    .loaduse_c    (loaduse)
  );

  // Next-state and Mealy output logic.
  always_comb begin
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    pending_redirect_d = pending_redirect_q;
    pc_write           = 1'b1;
    ifid_write         = 1'b1;
    ifid_flush         = 1'b0;
    idex_hold          = 1'b0;
    idex_bubble        = 1'b0;
    redirect           = ex_valid & branch_taken;
    do_run             = 1'b0;
    take_redirect      = 1'b0;

    case (state_q)
      RUN: do_run = 1'b1;

      FLUSH: begin
        if (mem_busy) begin
          // Freeze wins over the flush; count is held until memory frees up.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (flush_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          pc_write           = 1'b0;
          ifid_write         = 1'b0;
          idex_hold          = 1'b1;
          pending_redirect_d = pending_redirect_q | redirect;
        end else if (pending_redirect_q) begin
          take_redirect      = 1'b1;
          pending_redirect_d = 1'b0;
        end else begin
          do_run  = 1'b1;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase

    // Normal-flow priority: mem_busy > redirect > load-use.
    if (do_run) begin
      if (mem_busy) begin
        pc_write           = 1'b0;
        ifid_write         = 1'b0;
        idex_hold          = 1'b1;
        state_d            = MEM_WAIT;
        pending_redirect_d = redirect;
      end else if (redirect) begin
        take_redirect = 1'b1;
      end else if (loaduse) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    // First redirect cycle; remaining FLUSH_CYCLES-1 cycles run in FLUSH.
    if (take_redirect) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 2);
      end else begin
        state_d = RUN;
      end
    end

    // Reset holds the front end flushed and the PC frozen.
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_hold   = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // FSM state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= RUN;
      flush_cnt_q        <= '0;
      pending_redirect_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      pending_redirect_q <= pending_redirect_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  // Saturating event counters; reset cycles never count since flops are held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (ifid_flush && (flush_cycles_q != '1)) begin
      flush_cycles_d = flush_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with FLUSH_CYCLES=3.
module tb_pipeline_hazard_controller;

  localparam int unsigned RW = 5;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic          ex_valid;
  logic          reg_memRead;
  logic          reg_regWrite;
  logic [RW-1:0] ex_rd;
  logic          branch_taken;
  logic          mem_busy;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_hold;
  logic          idex_bubble;
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_cycles;

  int n_chk = 0;
  int n_bad = 0;

  pipeline_hazard_controller #(
    .CORE         (0),
    .REG_ADDR_W   (RW),
    .FLUSH_CYCLES (3)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_valid     (ex_valid),
    .reg_memRead  (reg_memRead),
    .reg_regWrite (reg_regWrite),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_hold    (idex_hold),
    .idex_bubble  (idex_bubble),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the five controls mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic e_pc, input logic e_ifw,
                     input logic e_fl, input logic e_hold, input logic e_bub);
    @(negedge clk);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(e_ifw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
    chk({tag, ".idex_hold"},   32'(idex_hold),   32'(e_hold));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
    @(posedge clk);
    #1;
  endtask

  // Expected counter value depends on whether the counters are built.
  function automatic logic [31:0] pc_exp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic chk_cnt(input string tag, input int e_stall, input int e_flush);
    chk({tag, ".stall_cycles"}, stall_cycles, pc_exp(e_stall));
    chk({tag, ".flush_cycles"}, flush_cycles, pc_exp(e_flush));
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; reg_memRead = 1'b0; reg_regWrite = 1'b0; ex_rd = '0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    // Reset with a branch pending: forced outputs throughout.
    ex_valid = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("rst", 0, 0);
    reset = 1'b1;
    idle();
    cyc("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("post_rst", 0, 0);

    // Load-use on rs2: one stall cycle, then EX holds a bubble.
    id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    ex_valid = 1'b1; reg_memRead = 1'b1; reg_regWrite = 1'b1; ex_rd = 5'd5;
    cyc("lu_rs2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_valid = 1'b0;
    cyc("lu_rs2_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Load into x0 never stalls.
    ex_valid = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    cyc("lu_x0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Load-use on rs1.
    id_uses_rs2 = 1'b0; id_uses_rs1 = 1'b1; id_rs1 = 5'd7; ex_rd = 5'd7;
    cyc("lu_rs1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Matching rs1 that is not read: no stall.
    id_uses_rs1 = 1'b0;
    cyc("lu_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Not a load: no stall.
    id_uses_rs1 = 1'b1; reg_memRead = 1'b0;
    cyc("lu_noload", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("lu", 2, 0);

    // Redirect: three flush cycles; branch_taken during FLUSH is ignored.
    idle();
    ex_valid = 1'b1; branch_taken = 1'b1;
    cyc("br_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("br_c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("br_c3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    branch_taken = 1'b0;
    cyc("br_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("br", 2, 3);

    // mem_busy and branch together: 4 frozen cycles, then the deferred flush.
    ex_valid = 1'b1; branch_taken = 1'b1; mem_busy = 1'b1;
    cyc("mb_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mb_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_busy = 1'b0; ex_valid = 1'b0;
    cyc("mb_fl1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("mb_fl2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("mb_fl3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("mb_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("mb", 6, 6);

    // mem_busy on the 2nd flush cycle for 2 cycles: flush still totals 3.
    ex_valid = 1'b1; branch_taken = 1'b1;
    cyc("fb_fl1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    branch_taken = 1'b0; ex_valid = 1'b0; mem_busy = 1'b1;
    cyc("fb_frz1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("fb_frz2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_busy = 1'b0;
    cyc("fb_fl2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("fb_fl3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("fb_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("fb", 8, 9);

    // Load-use and redirect together: redirect wins.
    id_valid = 1'b1; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    ex_valid = 1'b1; reg_memRead = 1'b1; reg_regWrite = 1'b1; ex_rd = 5'd9;
    branch_taken = 1'b1;
    cyc("lub_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    cyc("lub_c2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("lub_c3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("lub_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("lub", 8, 12);

    // Reset mid-MEM_WAIT discards the pending redirect and clears counters.
    ex_valid = 1'b1; branch_taken = 1'b1; mem_busy = 1'b1;
    cyc("rmw_frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc("rmw_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    idle();
    cyc("rmw_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rmw_after2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("rmw", 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
